// File: rtl/zloader_if.sv
// Byte-stream handshake from the boot source into the zloader.
interface zloader_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic [DATA_W-1:0] IN_DATA;
  logic              IN_VALID;
  logic              IN_LAST;
  logic              IN_READY;

  modport master (output IN_DATA, output IN_VALID, output IN_LAST, input IN_READY);
  modport slave  (input IN_DATA, input IN_VALID, input IN_LAST, output IN_READY);
endinterface

// File: rtl/zloader.sv
// Boot-time program loader: streams bytes into the zephyr RAM, zero-fills the rest, then releases the core.
// Optional trailing-checksum verification is built when ZLOADER_CHECKSUM_EN is defined.
module zloader #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  zloader_if.slave          in_if,
  output logic              RAM_WE,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_WDATA,
  output logic              CPU_RESET,
  output logic              DONE,
  output logic              ERROR,
  output logic [ADDR_W:0]   BYTE_COUNT
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_FILL = 3'd2,
    S_RUN  = 3'd3
`ifdef ZLOADER_CHECKSUM_EN
    ,
    S_CSUM = 3'd4,
    S_ERR  = 3'd5
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              ram_we_d;
  logic [ADDR_W-1:0] ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_d;
  logic              cpu_reset_d;
  logic              done_d;
  logic              restart_c;
  logic              hs_c;
  logic              last_byte_c;

`ifdef ZLOADER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
  logic              error_q, error_d;
`endif

  assign in_if.IN_READY = in_ready_q;
  assign hs_c           = in_if.IN_VALID & in_ready_q;
  // A byte ends the program if flagged last or if it fills the final RAM word.
  assign last_byte_c    = in_if.IN_LAST | (BYTE_COUNT == CNT_W'(DEPTH - 1));

  // State and output registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      BYTE_COUNT <= '0;
      in_ready_q <= 1'b0;
      RAM_WE     <= 1'b0;
      RAM_ADDR   <= '0;
      RAM_WDATA  <= '0;
      CPU_RESET  <= 1'b1;
      DONE       <= 1'b0;
`ifdef ZLOADER_CHECKSUM_EN
      csum_q     <= '0;
      error_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      BYTE_COUNT <= cnt_d;
      in_ready_q <= in_ready_d;
      RAM_WE     <= ram_we_d;
      RAM_ADDR   <= ram_addr_d;
      RAM_WDATA  <= ram_wdata_d;
      CPU_RESET  <= cpu_reset_d;
      DONE       <= done_d;
`ifdef ZLOADER_CHECKSUM_EN
      csum_q     <= csum_d;
      error_q    <= error_d;
`endif
    end
  end

`ifdef ZLOADER_CHECKSUM_EN
  assign ERROR = error_q;
`else
  assign ERROR = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = BYTE_COUNT;
    in_ready_d  = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = RAM_ADDR;
    ram_wdata_d = RAM_WDATA;
    cpu_reset_d = 1'b1;
    done_d      = 1'b0;
    restart_c   = 1'b0;
`ifdef ZLOADER_CHECKSUM_EN
    csum_d      = csum_q;
    error_d     = error_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (START) restart_c = 1'b1;
      end

      S_LOAD: begin
        in_ready_d = 1'b1;
        if (hs_c) begin
          ram_we_d    = 1'b1;
          ram_addr_d  = addr_q;
          ram_wdata_d = in_if.IN_DATA;
          addr_d      = addr_q + ADDR_W'(1);
          cnt_d       = BYTE_COUNT + CNT_W'(1);
`ifdef ZLOADER_CHECKSUM_EN
          csum_d      = csum_q + in_if.IN_DATA;
          if (last_byte_c) state_d = S_CSUM;
`else
          if (last_byte_c) begin
            in_ready_d = 1'b0;
            state_d    = (BYTE_COUNT == CNT_W'(DEPTH - 1)) ? S_RUN : S_FILL;
          end
`endif
        end
      end

`ifdef ZLOADER_CHECKSUM_EN
      S_CSUM: begin
        in_ready_d = 1'b1;
        if (hs_c) begin
          in_ready_d = 1'b0;
          if (in_if.IN_DATA == csum_q) begin
            state_d = (BYTE_COUNT < CNT_W'(DEPTH)) ? S_FILL : S_RUN;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
      end

      S_ERR: begin
        if (START) begin
          restart_c = 1'b1;
          error_d   = 1'b0;
        end
      end
`endif

      S_FILL: begin
        ram_we_d    = 1'b1;
        ram_addr_d  = addr_q;
        ram_wdata_d = '0;
        addr_d      = addr_q + ADDR_W'(1);
        if (addr_q == ADDR_W'(DEPTH - 1)) state_d = S_RUN;
      end

      S_RUN: begin
        // Core released only one edge after entering RUN, i.e. after the last write lands.
        cpu_reset_d = 1'b0;
        done_d      = 1'b1;
        if (START) restart_c = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase

    // Ready rises one edge after LOAD is entered.
    if (restart_c) begin
      state_d     = S_LOAD;
      addr_d      = '0;
      cnt_d       = '0;
      in_ready_d  = 1'b0;
      cpu_reset_d = 1'b1;
      done_d      = 1'b0;
`ifdef ZLOADER_CHECKSUM_EN
      csum_d      = '0;
`endif
    end
  end

endmodule

// File: tb/tb_zloader.sv
// Self-checking bench for zloader: table of load scenarios, write scoreboard, and hand-written corner sequences.
module tb_zloader;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;

  logic              CLK = 1'b0;
  logic              RESET_N = 1'b0;
  logic              START = 1'b0;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   byte_count;

  zloader_if #(.DATA_W(DATA_W)) bus ();

  zloader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .START      (START),
    .in_if      (bus.slave),
    .RAM_WE     (ram_we),
    .RAM_ADDR   (ram_addr),
    .RAM_WDATA  (ram_wdata),
    .CPU_RESET  (cpu_reset),
    .DONE       (done),
    .ERROR      (error),
    .BYTE_COUNT (byte_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct {
    int          n;
    bit          use_last;
    int          gap;
    logic [7:0]  base;
    int          exp_count;
    int          exp_writes;
  } vec_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_we_cyc = 0;
  int   fall_cyc = 0;
  int   wr_count = 0;
  logic prev_cpu_reset = 1'b1;
  logic [ADDR_W-1:0] addr_model = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Write monitor: every RAM strobe must match the head of the scoreboard.
  always @(negedge CLK) begin
    cyc++;
    if (ram_we === 1'b1) begin
      wr_count++;
      last_we_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write addr=%0h data=%0h at t=%0t", ram_addr, ram_wdata, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(ram_addr), 32'(mon_e.addr));
        check("wr_data", 32'(ram_wdata), 32'(mon_e.data));
      end
    end
    if (prev_cpu_reset && !cpu_reset) fall_cyc = cyc;
    prev_cpu_reset = cpu_reset;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      bus.IN_VALID = 1'b0;
      bus.IN_LAST  = 1'b0;
    end
  endtask

  task automatic start_load(input bit from_run);
    wr_count   = 0;
    fall_cyc   = 0;
    addr_model = '0;
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    if (from_run) begin
      check("reload_cpu_reset", 32'(cpu_reset), 32'd1);
      check("reload_done", 32'(done), 32'd0);
      check("reload_byte_count", 32'(byte_count), 32'd0);
    end
    @(negedge CLK);
    check("ready_after_start", 32'(bus.IN_READY), 32'd1);
  endtask

  // Offers one byte until accepted; returns at the negedge preceding the accepting edge.
  task automatic send_byte(input logic [7:0] d, input logic last, input bit push);
    int waited;
    bit got;
    waited = 0;
    got = 1'b0;
    while (!got && waited < 50) begin
      @(negedge CLK);
      bus.IN_VALID = 1'b1;
      bus.IN_DATA  = d;
      bus.IN_LAST  = last;
      if (bus.IN_READY === 1'b1) begin
        got = 1'b1;
        if (push) begin
          exp_q.push_back('{addr_model, d});
          addr_model = addr_model + ADDR_W'(1);
        end
      end else begin
        waited++;
      end
    end
    if (!got) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic push_fills(input int from);
    for (int a = from; a < DEPTH; a++) exp_q.push_back('{ADDR_W'(a), 8'h00});
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (done !== 1'b1 && k < 100) begin
      @(negedge CLK);
      k++;
    end
    check("done_seen", 32'(done), 32'd1);
    @(negedge CLK);
  endtask

  task automatic run_case(input vec_t v, input bit from_run);
    logic [7:0] sum;
    logic [7:0] d;
    int         exp_gap;
    sum = 8'h00;
    start_load(from_run);
    for (int j = 0; j < v.n; j++) begin
      if (j > 0 && v.gap > 0) idle(v.gap);
      d = v.base + 8'(j);
      send_byte(d, v.use_last && (j == v.n - 1), 1'b1);
      sum = sum + d;
    end
`ifdef ZLOADER_CHECKSUM_EN
    send_byte(sum, 1'b0, 1'b0);
    exp_gap = (v.n == DEPTH) ? 2 : 1;
`else
    exp_gap = 1;
`endif
    push_fills(v.n);
    idle(1);
    wait_done();
    check("byte_count", 32'(byte_count), 32'(v.exp_count));
    check("cpu_reset_run", 32'(cpu_reset), 32'd0);
    check("ready_in_run", 32'(bus.IN_READY), 32'd0);
    check("write_count", 32'(wr_count), 32'(v.exp_writes));
    check("release_gap", 32'(fall_cyc - last_we_cyc), 32'(exp_gap));
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
  endtask

  vec_t vecs[5];
  int   wc;

  initial begin
    bus.IN_VALID = 1'b0;
    bus.IN_LAST  = 1'b0;
    bus.IN_DATA  = '0;

    vecs[0] = '{16, 1'b0, 0, 8'h00, 16, 16};  // full load, data equals address
    vecs[1] = '{3,  1'b1, 0, 8'h41, 3,  16};  // short load, 13 fill writes
    vecs[2] = '{6,  1'b1, 2, 8'h80, 6,  16};  // valid pattern 1,0,0,1,...
    vecs[3] = '{16, 1'b1, 1, 8'hF8, 16, 16};  // redundant IN_LAST on final word
    vecs[4] = '{1,  1'b1, 0, 8'hAA, 1,  16};  // single byte, 15 fills

    #12;
    check("rst_in_ready", 32'(bus.IN_READY), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_byte_count", 32'(byte_count), 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_case(vecs[i], i > 0);
      if (i == 2) begin
        // Stream activity while running must be ignored.
        wc = wr_count;
        repeat (4) begin
          @(negedge CLK);
          bus.IN_VALID = 1'b1;
          bus.IN_DATA  = 8'hEE;
        end
        idle(3);
        check("run_ignores_valid_writes", 32'(wr_count), 32'(wc));
        check("run_ignores_valid_count", 32'(byte_count), 32'(vecs[i].exp_count));
        check("run_still_done", 32'(done), 32'd1);
      end
    end

    // Asynchronous reset in the middle of a load.
    start_load(1'b1);
    for (int j = 0; j < 5; j++) send_byte(8'h55 + 8'(j), 1'b0, 1'b1);
    idle(2);
    #2;
    RESET_N = 1'b0;
    #1;
    check("arst_in_ready", 32'(bus.IN_READY), 32'd0);
    check("arst_ram_we", 32'(ram_we), 32'd0);
    check("arst_ram_addr", 32'(ram_addr), 32'd0);
    check("arst_ram_wdata", 32'(ram_wdata), 32'd0);
    check("arst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("arst_done", 32'(done), 32'd0);
    check("arst_byte_count", 32'(byte_count), 32'd0);
    exp_q.delete();
    @(negedge CLK);
    RESET_N = 1'b1;
    idle(3);
    check("idle_after_reset_ready", 32'(bus.IN_READY), 32'd0);
    check("idle_after_reset_cpu", 32'(cpu_reset), 32'd1);
    run_case('{2, 1'b1, 0, 8'h07, 2, 16}, 1'b0);

`ifdef ZLOADER_CHECKSUM_EN
    // Good checksum: 0x10 + 0x20 = 0x30.
    start_load(1'b1);
    send_byte(8'h10, 1'b0, 1'b1);
    send_byte(8'h20, 1'b1, 1'b1);
    send_byte(8'h30, 1'b0, 1'b0);
    push_fills(2);
    idle(1);
    wait_done();
    check("csum_ok_count", 32'(byte_count), 32'd2);
    check("csum_ok_writes", 32'(wr_count), 32'd16);
    check("csum_ok_error", 32'(error), 32'd0);

    // Bad checksum: no fill, core held, error flagged.
    start_load(1'b1);
    send_byte(8'h10, 1'b0, 1'b1);
    send_byte(8'h20, 1'b1, 1'b1);
    send_byte(8'h31, 1'b1, 1'b0);
    idle(4);
    check("csum_bad_error", 32'(error), 32'd1);
    check("csum_bad_cpu_reset", 32'(cpu_reset), 32'd1);
    check("csum_bad_done", 32'(done), 32'd0);
    check("csum_bad_writes", 32'(wr_count), 32'd2);
    check("csum_bad_ready", 32'(bus.IN_READY), 32'd0);

    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    check("err_restart_error", 32'(error), 32'd0);
    @(negedge CLK);
    check("err_restart_ready", 32'(bus.IN_READY), 32'd1);
`endif

    idle(2);
    check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at t=%0t", $time);
    $fatal(1);
  end
endmodule
